// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the instruction fetch sequencer.
//  Revision : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_HELD     = 2'd2
    } fetch_state_e;

    localparam int         INST_BYTES    = 4;
    localparam int         INST_W        = 8 * INST_BYTES;
    // Opcode pattern 110xx11 covers BRANCH, JALR and JAL.
    localparam logic [6:0] CTRL_OP_MASK  = 7'b111_0011;
    localparam logic [6:0] CTRL_OP_VALUE = 7'b110_0011;

    function automatic logic is_ctrl_op(input logic [6:0] opcode);
        return (opcode & CTRL_OP_MASK) == CTRL_OP_VALUE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_skid
//  Brief    : One-entry holding register for a fetched word and its PC.
//  Revision : 1.0
// ============================================================================
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [INST_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [INST_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              full_o
);

    logic [INST_W-1:0] data_q;
    logic [ADDR_W-1:0] pc_q;
    logic              full_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            data_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
            full_q <= 1'b1;
        end
    end

    assign data_o = data_q;
    assign pc_o   = pc_q;
    assign full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Sequential instruction fetch from a 1-cycle BRAM with redirect,
//             halt and valid/ready backpressure toward decode.
//  Revision : 1.0
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_is_ctrl,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;

    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_full;
    logic [INST_W-1:0] w_skid_data;
    logic [ADDR_W-1:0] w_skid_pc;

    // A stalled INFLIGHT or HELD slot blocks issue, so at most one word is ever buffered.
    assign w_issue      = redirect_valid || (!halt && (out_ready || state_q == ST_EMPTY));
    assign w_issue_addr = redirect_valid ? (redirect_pc & ALIGN_MASK) : fetch_pc_q;
    assign mem_addr     = w_issue_addr;

    assign w_skid_load  = (state_q == ST_INFLIGHT) && !out_ready && !redirect_valid;
    assign w_skid_clear = redirect_valid || ((state_q == ST_HELD) && out_ready);

    fetch_skid #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_skid_load),
        .clear_i (w_skid_clear),
        .data_i  (mem_inst),
        .pc_i    (inflight_pc_q),
        .data_o  (w_skid_data),
        .pc_o    (w_skid_pc),
        .full_o  (w_skid_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            if (w_issue) begin
                fetch_pc_q    <= w_issue_addr + PC_STEP;
                inflight_pc_q <= w_issue_addr;
            end
            if (redirect_valid) begin
                state_q <= ST_INFLIGHT;
            end else begin
                case (state_q)
                    ST_EMPTY:
                        state_q <= w_issue ? ST_INFLIGHT : ST_EMPTY;
                    ST_INFLIGHT, ST_HELD:
                        if (out_ready) state_q <= w_issue ? ST_INFLIGHT : ST_EMPTY;
                        else           state_q <= ST_HELD;
                    default:
                        state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign out_valid   = !rst && !redirect_valid && (state_q != ST_EMPTY);
    assign out_inst    = w_skid_full ? w_skid_data : mem_inst;
    assign out_pc      = w_skid_full ? w_skid_pc : inflight_pc_q;
    assign out_is_ctrl = out_valid && is_ctrl_op(out_inst[6:0]);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Brief    : Scoreboard bench: expected fetch stream queued by stimulus,
//             consumed by a monitor on each decode transfer.
//  Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

    localparam int         ADDR_W    = 8;
    localparam logic [7:0] RESET_PC  = 8'h00;
    localparam int         STALL_MAX = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_addr;
    logic [31:0] mem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic        out_is_ctrl;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_is_ctrl    (out_is_ctrl),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    always @(posedge clk) mem_inst <= mem[mem_addr[7:2]];

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] inst;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_pc;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_is_ctrl(input logic [31:0] w);
        return (w[6:4] == 3'b110) && (w[1:0] == 2'b11);
    endfunction

    // The architectural stream: consecutive words starting from the last target.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_pc, inst: mem[model_pc / 4]});
            model_pc = model_pc + 8'd4;
        end
    endtask

    task automatic restart(input logic [7:0] target);
        exp_q.delete();
        model_pc = target - (target % 8'd4);
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        out_ready      = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_is_ctrl, 0);
        chk("rst_fetch_pc", mem_addr, RESET_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart(RESET_PC);
    endtask

    // Monitor
    logic        prev_rst  = 1'b1;
    logic        prev_halt = 1'b0;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_pc;
    logic [31:0] hold_inst;
    int          stall_cnt = 0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
            hold_pend = 1'b0;
        end else begin
            if (redirect_valid)
                chk("redirect_valid_low", out_valid, 0);
            else if (!prev_rst && !prev_halt)
                chk("valid_expected", out_valid, 1);
            if (prev_rst && !redirect_valid)
                chk("first_issue_addr", mem_addr, RESET_PC);
            if (hold_pend && !redirect_valid) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_pc", out_pc, hold_pc);
                chk("hold_inst", out_inst, hold_inst);
            end
            if (!out_valid)
                chk("ctrl_gated", out_is_ctrl, 0);
            if (out_valid && out_ready) begin
                stall_cnt = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra actual_pc=%0h expected=none", out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_pc", out_pc, mon_e.pc);
                    chk("stream_inst", out_inst, mon_e.inst);
                    chk("stream_ctrl", out_is_ctrl, ref_is_ctrl(mon_e.inst));
                end
            end else begin
                stall_cnt++;
                if (stall_cnt >= STALL_MAX) begin
                    checks++;
                    errors++;
                    $display("FAIL liveness stalled=%0d cycles required<%0d", stall_cnt, STALL_MAX);
                    stall_cnt = 0;
                end
            end
            hold_pend = out_valid && !out_ready && !redirect_valid;
            hold_pc   = out_pc;
            hold_inst = out_inst;
        end
        prev_rst  = rst;
        prev_halt = halt;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [6:0] ops [8] = '{7'h6F, 7'h67, 7'h63, 7'h6B, 7'h13, 7'h33, 7'h73, 7'h43};

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        model_pc       = RESET_PC;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        mem[20] = 32'h0000006F;
        mem[21] = 32'h00000013;
        mem[22] = 32'h00000063;
        mem[23] = 32'h00000067;

        // Sequential stream from reset, full throughput.
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t034_bubble", out_valid, 0);
        chk("t034_first_addr", mem_addr, RESET_PC);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("t034_valid", out_valid, 1);
            chk("t034_pc", out_pc, 32'(4 * k));
            chk("t034_inst", out_inst, 32'(k));
        end

        // Three-cycle stall on pc 8.
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t035_stall_pc", out_pc, 8'd8);
            chk("t035_stall_inst", out_inst, 32'd2);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t035_release_pc", out_pc, 8'd8);
        step();
        @(negedge clk);
        chk("t035_next_pc", out_pc, 8'd12);
        step();
        @(negedge clk);
        chk("t035_next2_pc", out_pc, 8'd16);

        // Redirect to an unaligned target while HELD.
        do_reset();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        @(negedge clk);
        chk("t036_held_pc", out_pc, 8'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h43;
        restart(8'h43);
        @(negedge clk);
        chk("t036_redir_valid", out_valid, 0);
        chk("t036_redir_addr", mem_addr, 8'h40);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        chk("t036_target_valid", out_valid, 1);
        chk("t036_target_pc", out_pc, 8'h40);
        chk("t036_target_inst", out_inst, 32'd16);
        step();
        @(negedge clk);
        chk("t036_next_pc", out_pc, 8'h44);

        // Address wrap.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'd248;
        restart(8'd248);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t037_pc248", out_pc, 8'd248);
        step();
        @(negedge clk);
        chk("t037_pc252", out_pc, 8'd252);
        step();
        @(negedge clk);
        chk("t037_pc0", out_pc, 8'd0);
        chk("t037_inst0", out_inst, 32'd0);

        // Control opcode detection.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h50;
        restart(8'h50);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t038_jal_inst", out_inst, 32'h6F);
        chk("t038_jal_ctrl", out_is_ctrl, 1);
        step();
        @(negedge clk);
        chk("t038_addi_ctrl", out_is_ctrl, 0);
        step();
        @(negedge clk);
        chk("t038_branch_ctrl", out_is_ctrl, 1);
        step();
        @(negedge clk);
        chk("t038_jalr_ctrl", out_is_ctrl, 1);

        // Halt while INFLIGHT on pc 20.
        do_reset();
        out_ready = 1'b1;
        repeat (6) step();
        halt = 1'b1;
        @(negedge clk);
        chk("t039_pc20_valid", out_valid, 1);
        chk("t039_pc20", out_pc, 8'd20);
        for (int j = 0; j < 2; j++) begin
            step();
            @(negedge clk);
            chk("t039_drained", out_valid, 0);
            chk("t039_fetch_pc", mem_addr, 8'd24);
        end
        step();
        halt = 1'b0;
        @(negedge clk);
        chk("t039_resume_addr", mem_addr, 8'd24);
        step();
        @(negedge clk);
        chk("t039_resume_pc", out_pc, 8'd24);

        // Randomized traffic over random memory contents.
        rst = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom()} & 32'hFFFF_FF80 | 32'(ops[$urandom_range(0, 7)]);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 399) == 0) begin
                rst            = 1'b1;
                redirect_valid = 1'b0;
                repeat ($urandom_range(1, 2)) step();
                rst = 1'b0;
                restart(RESET_PC);
            end
            out_ready      = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if (redirect_valid) begin
                redirect_pc = 8'($urandom());
                restart(redirect_pc);
            end
        end
        redirect_valid = 1'b0;
        halt           = 1'b0;
        out_ready      = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
